// File: rtl/rv32i_types_pkg.sv
// Shared RV32 decode types: opcodes, immediate formats, ALU ops, mux selects.
// RV32M_DECODE_EN adds the M-extension ALU operations.
package rv32i_types_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_I_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_J      = 7'b1101111;
    localparam logic [6:0] OP_I_JUMP = 7'b1100111;
    localparam logic [6:0] OP_U      = 7'b0110111;
    localparam logic [6:0] OP_U_PC   = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_t;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
`ifdef RV32M_DECODE_EN
        , ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
`endif
    } ALU_op_options_t;

    typedef enum logic {ALU_A_RS1, ALU_A_PC} alu_a_sel_t;
    typedef enum logic {ALU_B_RS2, ALU_B_IMMEDIATE} alu_b_sel_t;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC_PLUS_4} wb_sel_t;

    typedef struct packed {
        logic            valid;
        logic            illegal;
        logic            jump;
        logic            i_jump;
        logic            branch;
        logic [2:0]      cond_code;
        ALU_op_options_t alu_op;
        alu_a_sel_t      a_sel;
        alu_b_sel_t      b_sel;
        logic            memory_transaction;
        logic            mem_write;
        logic [2:0]      width_type;
        logic            reg_write;
        wb_sel_t         wb_sel;
    } ctrl_t;

    function automatic logic [31:0] build_imm(logic [31:0] i, imm_type_t t);
        case (t)
            IMM_I:   return {{20{i[31]}}, i[31:20]};
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   return {i[31:12], 12'b0};
            IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_pipe_stage_regfile.sv
// Two-read/one-write register file with x0 hardwired to zero and
// write-first bypass from the writeback port.
module regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  async_rst_n,
    input  logic [4:0]            read_addr_1,
    input  logic [4:0]            read_addr_2,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    input  logic                  write_enable,
    input  logic [4:0]            write_addr,
    input  logic [DATA_WIDTH-1:0] write_data
);

    localparam int AW = $clog2(REG_COUNT);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic                  write_ok;

    assign write_ok = write_enable && (write_addr != 5'd0)
                      && (int'(write_addr) < REG_COUNT);

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[write_addr[AW-1:0]] <= write_data;
        end
    end

    // Out-of-range indices read zero; such instructions are flagged illegal.
    always_comb begin
        read_data_1 = regs[read_addr_1[AW-1:0]];
        if (read_addr_1 == 5'd0 || int'(read_addr_1) >= REG_COUNT) begin
            read_data_1 = '0;
        end else if (write_ok && write_addr == read_addr_1) begin
            read_data_1 = write_data;
        end
    end

    always_comb begin
        read_data_2 = regs[read_addr_2[AW-1:0]];
        if (read_addr_2 == 5'd0 || int'(read_addr_2) >= REG_COUNT) begin
            read_data_2 = '0;
        end else if (write_ok && write_addr == read_addr_2) begin
            read_data_2 = write_data;
        end
    end

endmodule

// File: rtl/decode_pipe_stage.sv
// Registered RV32 decode stage: F/D and D/E registers, regfile, load-use stall.
// Define RV32M_DECODE_EN to decode the M-extension R-type operations.
module decode_pipe_stage
    import rv32i_types_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          REG_COUNT  = 32,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                  clk,
    input  logic                  async_rst_n,
    input  logic                  valid_F,
    input  logic [31:0]           instr_F,
    input  logic [31:0]           PC_F,
    output logic                  stall_F,
    input  logic                  flush_D,
    input  logic                  rf_write_enable_W,
    input  logic [4:0]            rf_write_addr_W,
    input  logic [31:0]           rf_write_data_W,
    output logic                  valid_E,
    output logic                  illegal_E,
    output logic                  jump_E,
    output logic                  i_jump_E,
    output logic                  branch_E,
    output logic [2:0]            cond_code_E,
    output ALU_op_options_t       ALU_op_E,
    output alu_a_sel_t            mux_ALU_operand_A_select_E,
    output alu_b_sel_t            mux_ALU_operand_B_select_E,
    output logic                  memory_transaction_E,
    output logic                  mem_write_E,
    output logic [2:0]            width_type_E,
    output logic                  reg_write_E,
    output wb_sel_t               mux_writeback_select_E,
    output logic [4:0]            rs1_E,
    output logic [4:0]            rs2_E,
    output logic [4:0]            rd_E,
    output logic [DATA_WIDTH-1:0] operand_1_E,
    output logic [DATA_WIDTH-1:0] operand_2_E,
    output logic [DATA_WIDTH-1:0] immediate_E,
    output logic [DATA_WIDTH-1:0] PC_E,
    output logic [DATA_WIDTH-1:0] predicted_PC_E
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("decode_pipe_stage supports DATA_WIDTH = 32 only");
    end

    logic        fd_valid;
    logic [31:0] fd_instr;
    logic [31:0] fd_pc;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode = fd_instr[6:0];
    assign rd     = fd_instr[11:7];
    assign funct3 = fd_instr[14:12];
    assign rs1    = fd_instr[19:15];
    assign rs2    = fd_instr[24:20];
    assign funct7 = fd_instr[31:25];

    ctrl_t                 ctrl;
    ctrl_t                 de_ctrl;
    imm_type_t             imm_type;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  uses_rd;
    logic                  bad_funct;
    logic [31:0]           immediate;
    logic [31:0]           predicted_pc;
    logic [DATA_WIDTH-1:0] rdata_1;
    logic [DATA_WIDTH-1:0] rdata_2;

    function automatic logic reg_bad(logic used, logic [4:0] r);
        return used && (int'(r) >= REG_COUNT);
    endfunction

    always_comb begin
        ctrl       = '0;
        ctrl.valid = 1'b1;
        imm_type   = IMM_NONE;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        uses_rd    = 1'b0;
        bad_funct  = 1'b0;
        unique case (opcode)
            OP_R: begin
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                uses_rd        = 1'b1;
                ctrl.reg_write = 1'b1;
                unique case ({funct7, funct3})
                    {F7_BASE, 3'd0}: ctrl.alu_op = ALU_ADD;
                    {F7_ALT, 3'd0}:  ctrl.alu_op = ALU_SUB;
                    {F7_BASE, 3'd1}: ctrl.alu_op = ALU_SLL;
                    {F7_BASE, 3'd2}: ctrl.alu_op = ALU_SLT;
                    {F7_BASE, 3'd3}: ctrl.alu_op = ALU_SLTU;
                    {F7_BASE, 3'd4}: ctrl.alu_op = ALU_XOR;
                    {F7_BASE, 3'd5}: ctrl.alu_op = ALU_SRL;
                    {F7_ALT, 3'd5}:  ctrl.alu_op = ALU_SRA;
                    {F7_BASE, 3'd6}: ctrl.alu_op = ALU_OR;
                    {F7_BASE, 3'd7}: ctrl.alu_op = ALU_AND;
`ifdef RV32M_DECODE_EN
                    {F7_MULDIV, 3'd0}: ctrl.alu_op = ALU_MUL;
                    {F7_MULDIV, 3'd1}: ctrl.alu_op = ALU_MULH;
                    {F7_MULDIV, 3'd2}: ctrl.alu_op = ALU_MULHSU;
                    {F7_MULDIV, 3'd3}: ctrl.alu_op = ALU_MULHU;
                    {F7_MULDIV, 3'd4}: ctrl.alu_op = ALU_DIV;
                    {F7_MULDIV, 3'd5}: ctrl.alu_op = ALU_DIVU;
                    {F7_MULDIV, 3'd6}: ctrl.alu_op = ALU_REM;
                    {F7_MULDIV, 3'd7}: ctrl.alu_op = ALU_REMU;
`endif
                    default: bad_funct = 1'b1;
                endcase
            end
            OP_I_ALU: begin
                imm_type       = IMM_I;
                uses_rs1       = 1'b1;
                uses_rd        = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.b_sel     = ALU_B_IMMEDIATE;
                unique case (funct3)
                    3'd0: ctrl.alu_op = ALU_ADD;
                    3'd2: ctrl.alu_op = ALU_SLT;
                    3'd3: ctrl.alu_op = ALU_SLTU;
                    3'd4: ctrl.alu_op = ALU_XOR;
                    3'd6: ctrl.alu_op = ALU_OR;
                    3'd7: ctrl.alu_op = ALU_AND;
                    3'd1: begin
                        ctrl.alu_op = ALU_SLL;
                        bad_funct   = (funct7 != F7_BASE);
                    end
                    default: begin
                        ctrl.alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        bad_funct   = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                endcase
            end
            OP_I_LOAD: begin
                imm_type                = IMM_I;
                uses_rs1                = 1'b1;
                uses_rd                 = 1'b1;
                ctrl.reg_write          = 1'b1;
                ctrl.b_sel              = ALU_B_IMMEDIATE;
                ctrl.memory_transaction = 1'b1;
                ctrl.width_type         = funct3;
                ctrl.wb_sel             = WB_MEM;
                bad_funct = (funct3 == 3'd3) || (funct3 > 3'd5);
            end
            OP_S: begin
                imm_type                = IMM_S;
                uses_rs1                = 1'b1;
                uses_rs2                = 1'b1;
                ctrl.b_sel              = ALU_B_IMMEDIATE;
                ctrl.memory_transaction = 1'b1;
                ctrl.mem_write          = 1'b1;
                ctrl.width_type         = funct3;
                bad_funct               = (funct3 > 3'd2);
            end
            OP_B: begin
                imm_type       = IMM_B;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                ctrl.branch    = 1'b1;
                ctrl.cond_code = funct3;
                ctrl.alu_op    = ALU_SUB;
                bad_funct      = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            OP_J: begin
                imm_type       = IMM_J;
                uses_rd        = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.a_sel     = ALU_A_PC;
                ctrl.b_sel     = ALU_B_IMMEDIATE;
                ctrl.wb_sel    = WB_PC_PLUS_4;
            end
            OP_I_JUMP: begin
                imm_type       = IMM_I;
                uses_rs1       = 1'b1;
                uses_rd        = 1'b1;
                ctrl.i_jump    = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.b_sel     = ALU_B_IMMEDIATE;
                ctrl.wb_sel    = WB_PC_PLUS_4;
                bad_funct      = (funct3 != 3'd0);
            end
            OP_U: begin
                imm_type       = IMM_U;
                uses_rd        = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_PASS_B;
                ctrl.b_sel     = ALU_B_IMMEDIATE;
            end
            OP_U_PC: begin
                imm_type       = IMM_U;
                uses_rd        = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.a_sel     = ALU_A_PC;
                ctrl.b_sel     = ALU_B_IMMEDIATE;
            end
            default: bad_funct = 1'b1;
        endcase
        if (bad_funct || reg_bad(uses_rs1, rs1) || reg_bad(uses_rs2, rs2)
            || reg_bad(uses_rd, rd)) begin
            ctrl.illegal            = 1'b1;
            ctrl.reg_write          = 1'b0;
            ctrl.memory_transaction = 1'b0;
            ctrl.mem_write          = 1'b0;
            ctrl.jump               = 1'b0;
            ctrl.i_jump             = 1'b0;
            ctrl.branch             = 1'b0;
        end
    end

    assign immediate    = build_imm(fd_instr, imm_type);
    assign predicted_pc = (imm_type == IMM_J || imm_type == IMM_B)
                          ? fd_pc + immediate : fd_pc + 32'd4;

    // The bubble this inserts removes the load from D/E, so it lasts one cycle.
    assign stall_F = fd_valid && valid_E && memory_transaction_E
                     && !mem_write_E && (rd_E != 5'd0)
                     && ((uses_rs1 && rs1 == rd_E) || (uses_rs2 && rs2 == rd_E));

    regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .REG_COUNT (REG_COUNT)
    ) u_regfile (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .read_addr_1 (rs1),
        .read_addr_2 (rs2),
        .read_data_1 (rdata_1),
        .read_data_2 (rdata_2),
        .write_enable(rf_write_enable_W),
        .write_addr  (rf_write_addr_W),
        .write_data  (rf_write_data_W)
    );

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            fd_valid <= 1'b0;
            fd_instr <= '0;
            fd_pc    <= '0;
        end else if (flush_D) begin
            fd_valid <= 1'b0;
        end else if (!stall_F) begin
            fd_valid <= valid_F;
            fd_instr <= instr_F;
            fd_pc    <= PC_F;
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            de_ctrl        <= '0;
            rs1_E          <= '0;
            rs2_E          <= '0;
            rd_E           <= '0;
            operand_1_E    <= '0;
            operand_2_E    <= '0;
            immediate_E    <= '0;
            PC_E           <= RESET_PC;
            predicted_PC_E <= '0;
        end else begin
            de_ctrl        <= (stall_F || flush_D || !fd_valid) ? '0 : ctrl;
            rs1_E          <= rs1;
            rs2_E          <= rs2;
            rd_E           <= rd;
            operand_1_E    <= rdata_1;
            operand_2_E    <= rdata_2;
            immediate_E    <= immediate;
            PC_E           <= fd_pc;
            predicted_PC_E <= predicted_pc;
        end
    end

    assign valid_E                    = de_ctrl.valid;
    assign illegal_E                  = de_ctrl.illegal;
    assign jump_E                     = de_ctrl.jump;
    assign i_jump_E                   = de_ctrl.i_jump;
    assign branch_E                   = de_ctrl.branch;
    assign cond_code_E                = de_ctrl.cond_code;
    assign ALU_op_E                   = de_ctrl.alu_op;
    assign mux_ALU_operand_A_select_E = de_ctrl.a_sel;
    assign mux_ALU_operand_B_select_E = de_ctrl.b_sel;
    assign memory_transaction_E       = de_ctrl.memory_transaction;
    assign mem_write_E                = de_ctrl.mem_write;
    assign width_type_E               = de_ctrl.width_type;
    assign reg_write_E                = de_ctrl.reg_write;
    assign mux_writeback_select_E     = de_ctrl.wb_sel;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed bench for decode_pipe_stage with a cycle-stamped scoreboard;
// a second RV32E instance shares the stimulus.
module tb_decode_pipe_stage;
    import rv32i_types_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        async_rst_n, valid_F, flush_D, rf_write_enable_W;
    logic [31:0] instr_F, PC_F, rf_write_data_W;
    logic [4:0]  rf_write_addr_W;

    logic            stall_F, valid_E, illegal_E, jump_E, i_jump_E, branch_E;
    logic [2:0]      cond_code_E, width_type_E;
    ALU_op_options_t ALU_op_E;
    alu_a_sel_t      a_sel_E;
    alu_b_sel_t      b_sel_E;
    logic            memory_transaction_E, mem_write_E, reg_write_E;
    wb_sel_t         wb_sel_E;
    logic [4:0]      rs1_E, rs2_E, rd_E;
    logic [31:0]     operand_1_E, operand_2_E, immediate_E, PC_E, predicted_PC_E;

    logic            e_stall_F, e_valid_E, e_illegal_E, e_jump_E, e_i_jump_E, e_branch_E;
    logic [2:0]      e_cond_code_E, e_width_type_E;
    ALU_op_options_t e_ALU_op_E;
    alu_a_sel_t      e_a_sel_E;
    alu_b_sel_t      e_b_sel_E;
    logic            e_memory_transaction_E, e_mem_write_E, e_reg_write_E;
    wb_sel_t         e_wb_sel_E;
    logic [4:0]      e_rs1_E, e_rs2_E, e_rd_E;
    logic [31:0]     e_operand_1_E, e_operand_2_E, e_immediate_E, e_PC_E, e_predicted_PC_E;

    decode_pipe_stage #(.DATA_WIDTH(32), .REG_COUNT(32), .RESET_PC(32'h1000)) dut (
        .clk(clk), .async_rst_n(async_rst_n), .valid_F(valid_F), .instr_F(instr_F),
        .PC_F(PC_F), .stall_F(stall_F), .flush_D(flush_D),
        .rf_write_enable_W(rf_write_enable_W), .rf_write_addr_W(rf_write_addr_W),
        .rf_write_data_W(rf_write_data_W), .valid_E(valid_E), .illegal_E(illegal_E),
        .jump_E(jump_E), .i_jump_E(i_jump_E), .branch_E(branch_E),
        .cond_code_E(cond_code_E), .ALU_op_E(ALU_op_E),
        .mux_ALU_operand_A_select_E(a_sel_E), .mux_ALU_operand_B_select_E(b_sel_E),
        .memory_transaction_E(memory_transaction_E), .mem_write_E(mem_write_E),
        .width_type_E(width_type_E), .reg_write_E(reg_write_E),
        .mux_writeback_select_E(wb_sel_E), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
        .operand_1_E(operand_1_E), .operand_2_E(operand_2_E),
        .immediate_E(immediate_E), .PC_E(PC_E), .predicted_PC_E(predicted_PC_E)
    );

    decode_pipe_stage #(.DATA_WIDTH(32), .REG_COUNT(16), .RESET_PC(32'h1000)) dut_e (
        .clk(clk), .async_rst_n(async_rst_n), .valid_F(valid_F), .instr_F(instr_F),
        .PC_F(PC_F), .stall_F(e_stall_F), .flush_D(flush_D),
        .rf_write_enable_W(rf_write_enable_W), .rf_write_addr_W(rf_write_addr_W),
        .rf_write_data_W(rf_write_data_W), .valid_E(e_valid_E), .illegal_E(e_illegal_E),
        .jump_E(e_jump_E), .i_jump_E(e_i_jump_E), .branch_E(e_branch_E),
        .cond_code_E(e_cond_code_E), .ALU_op_E(e_ALU_op_E),
        .mux_ALU_operand_A_select_E(e_a_sel_E), .mux_ALU_operand_B_select_E(e_b_sel_E),
        .memory_transaction_E(e_memory_transaction_E), .mem_write_E(e_mem_write_E),
        .width_type_E(e_width_type_E), .reg_write_E(e_reg_write_E),
        .mux_writeback_select_E(e_wb_sel_E), .rs1_E(e_rs1_E), .rs2_E(e_rs2_E),
        .rd_E(e_rd_E), .operand_1_E(e_operand_1_E), .operand_2_E(e_operand_2_E),
        .immediate_E(e_immediate_E), .PC_E(e_PC_E), .predicted_PC_E(e_predicted_PC_E)
    );

    typedef enum {
        F_VALID, F_ILLEGAL, F_RS1, F_RS2, F_RD, F_IMM, F_ALUOP, F_BSEL,
        F_REGWR, F_BRANCH, F_JUMP, F_PPC, F_OP1, F_OP2, F_PC
    } fld_t;

    typedef struct {
        string       tag;
        int          due;
        fld_t        f;
        logic [31:0] v;
    } sb_t;

    sb_t sb[$];
    int  cyc_n  = 0;
    int  checks = 0;
    int  errors = 0;

    function automatic logic [31:0] obs(fld_t f);
        case (f)
            F_VALID:   return {31'b0, valid_E};
            F_ILLEGAL: return {31'b0, illegal_E};
            F_RS1:     return {27'b0, rs1_E};
            F_RS2:     return {27'b0, rs2_E};
            F_RD:      return {27'b0, rd_E};
            F_IMM:     return immediate_E;
            F_ALUOP:   return 32'(ALU_op_E);
            F_BSEL:    return 32'(b_sel_E);
            F_REGWR:   return {31'b0, reg_write_E};
            F_BRANCH:  return {31'b0, branch_E};
            F_JUMP:    return {31'b0, jump_E};
            F_PPC:     return predicted_PC_E;
            F_OP1:     return operand_1_E;
            F_OP2:     return operand_2_E;
            default:   return PC_E;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic want(string tag, int due, fld_t f, logic [31:0] v);
        sb.push_back('{tag, due, f, v});
    endtask

    task automatic tick();
        @(posedge clk);
        cyc_n++;
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc_n) begin
                chk(sb[i].tag, obs(sb[i].f), sb[i].v);
                sb.delete(i);
            end
        end
    endtask

    task automatic issue(logic [31:0] ins, logic [31:0] pc);
        valid_F = 1'b1;
        instr_F = ins;
        PC_F    = pc;
    endtask

    task automatic nop();
        valid_F = 1'b0;
        instr_F = 32'h0;
    endtask

    task automatic set_w(logic en, logic [4:0] a, logic [31:0] dat);
        rf_write_enable_W = en;
        rf_write_addr_W   = a;
        rf_write_data_W   = dat;
    endtask

    localparam logic [31:0] ADD_X6_X5 = 32'h00028333;
    localparam logic [31:0] LW_X2     = 32'h0000A103;
    localparam logic [31:0] ADD_X3_X2 = 32'h002101B3;

    initial begin
        int d;
        async_rst_n = 1'b0;
        flush_D     = 1'b0;
        nop();
        PC_F = 32'h0;
        set_w(1'b1, 5'd5, 32'h12345678);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, valid_E}, 32'd0);
        chk("rst_pc", PC_E, 32'h1000);
        chk("rst_stall", {31'b0, stall_F}, 32'd0);
        chk("rst_regwr", {31'b0, reg_write_E}, 32'd0);
        chk("rst_imm", immediate_E, 32'd0);
        @(negedge clk);
        async_rst_n = 1'b1;
        set_w(1'b0, 5'd0, 32'h0);

        issue(32'h00500093, 32'h0); d = cyc_n + 2;
        want("addi_valid", d, F_VALID, 1);
        want("addi_rd", d, F_RD, 1);
        want("addi_imm", d, F_IMM, 5);
        want("addi_aluop", d, F_ALUOP, 32'(ALU_ADD));
        want("addi_bsel", d, F_BSEL, 32'(ALU_B_IMMEDIATE));
        want("addi_regwr", d, F_REGWR, 1);
        want("addi_ppc", d, F_PPC, 32'h4);
        tick();

        issue(32'hFE000CE3, 32'h100); d = cyc_n + 2;
        want("beq_imm", d, F_IMM, 32'hFFFFFFF8);
        want("beq_branch", d, F_BRANCH, 1);
        want("beq_ppc", d, F_PPC, 32'hF8);
        want("beq_regwr", d, F_REGWR, 0);
        tick();

        issue(ADD_X6_X5, 32'h104); d = cyc_n + 2;
        want("rf_reset_write_ignored", d, F_OP1, 0);
        want("add_rs1", d, F_RS1, 5);
        want("add_pc", d, F_PC, 32'h104);
        tick();

        issue(ADD_X6_X5, 32'h108); d = cyc_n + 2;
        want("fwd_op1", d, F_OP1, 32'hDEADBEEF);
        want("fwd_op2", d, F_OP2, 0);
        tick();
        set_w(1'b1, 5'd5, 32'hDEADBEEF);
        issue(ADD_X6_X5, 32'h10C); d = cyc_n + 2;
        want("rf_read_op1", d, F_OP1, 32'hDEADBEEF);
        want("x0_no_fwd_op2", d, F_OP2, 0);
        tick();
        set_w(1'b1, 5'd0, 32'hFFFFFFFF);
        issue(32'h010000EF, 32'h200); d = cyc_n + 2;
        want("jal_jump", d, F_JUMP, 1);
        want("jal_ppc", d, F_PPC, 32'h210);
        want("jal_imm", d, F_IMM, 32'h10);
        tick();
        set_w(1'b0, 5'd0, 32'h0);

        issue(32'h12345237, 32'h204); d = cyc_n + 2;
        want("lui_imm", d, F_IMM, 32'h12345000);
        want("lui_aluop", d, F_ALUOP, 32'(ALU_PASS_B));
        tick();

        issue(32'h4030D093, 32'h208); d = cyc_n + 2;
        want("srai_aluop", d, F_ALUOP, 32'(ALU_SRA));
        want("srai_illegal", d, F_ILLEGAL, 0);
        tick();

        issue(32'h40309093, 32'h20C); d = cyc_n + 2;
        want("slli_bad_f7_illegal", d, F_ILLEGAL, 1);
        want("slli_bad_f7_valid", d, F_VALID, 1);
        want("slli_bad_f7_regwr", d, F_REGWR, 0);
        tick();

        issue(32'hFFFFFFFF, 32'h210); d = cyc_n + 2;
        want("bad_opcode_illegal", d, F_ILLEGAL, 1);
        tick();

        issue(32'h022081B3, 32'h214); d = cyc_n + 2;
`ifdef RV32M_DECODE_EN
        want("mul_aluop", d, F_ALUOP, 32'(ALU_MUL));
        want("mul_illegal", d, F_ILLEGAL, 0);
        want("mul_regwr", d, F_REGWR, 1);
`else
        want("mul_illegal", d, F_ILLEGAL, 1);
        want("mul_regwr", d, F_REGWR, 0);
        want("mul_valid", d, F_VALID, 1);
`endif
        tick();

        issue(32'h000008B3, 32'h218); d = cyc_n + 2;
        want("x17_rv32i_legal", d, F_ILLEGAL, 0);
        want("x17_rd", d, F_RD, 17);
        tick();
        nop();
        tick();
        chk("x17_rv32e_illegal", {31'b0, e_illegal_E}, 32'd1);
        chk("x17_rv32e_valid", {31'b0, e_valid_E}, 32'd1);
        chk("x17_rv32e_regwr", {31'b0, e_reg_write_E}, 32'd0);

        issue(LW_X2, 32'h300); d = cyc_n + 2;
        want("lw_valid", d, F_VALID, 1);
        want("lw_rd", d, F_RD, 2);
        tick();
        issue(ADD_X3_X2, 32'h304); d = cyc_n + 2;
        want("stall_bubble", d, F_VALID, 0);
        want("after_stall_valid", d + 1, F_VALID, 1);
        want("after_stall_rs1", d + 1, F_RS1, 2);
        want("after_stall_rs2", d + 1, F_RS2, 2);
        want("after_stall_rd", d + 1, F_RD, 3);
        tick();
        chk("stall_set", {31'b0, stall_F}, 32'd1);
        tick();
        chk("stall_one_cycle", {31'b0, stall_F}, 32'd0);
        nop();
        tick();

        issue(LW_X2, 32'h400); d = cyc_n + 2;
        want("flush_lw_valid", d, F_VALID, 1);
        tick();
        issue(ADD_X3_X2, 32'h404); d = cyc_n + 2;
        want("flush_edge1", d, F_VALID, 0);
        want("flush_edge2", d + 1, F_VALID, 0);
        want("flush_discarded", d + 2, F_VALID, 0);
        tick();
        chk("flush_stall_set", {31'b0, stall_F}, 32'd1);
        flush_D = 1'b1;
        tick();
        flush_D = 1'b0;
        nop();
        chk("flush_stall_gone", {31'b0, stall_F}, 32'd0);
        repeat (3) tick();

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
